// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StWrite,
    StChk,
    StDone,
    StErr
  } state_e;

  localparam logic [15:0] BaseAddrDefault = 16'h0000;
  localparam int unsigned MaxWordsDefault = 32768;
  localparam logic [15:0] WordStep        = 16'd2;

endpackage

// File: rtl/imem_loader_dff.sv
// Enabled D flip-flop bank with synchronous active-high reset to a fixed value.
module imem_loader_dff #(
  parameter int unsigned       Width    = 16,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wen_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= ResetVal;
    end else if (wen_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream of big-endian 16-bit instructions into
// instruction memory and keeps the core in reset until a clean load has completed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = BaseAddrDefault,
  parameter int unsigned MAX_WORDS = MaxWordsDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_in_i,
  output logic        byte_ready_o,
  output logic        mem_en_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_data_o,
  output logic        done_o,
  output logic        err_o,
  output logic        core_rst_n_o
);

  state_e      state_q;
  logic [15:0] len_q;
  logic [15:0] count_q;
  logic [7:0]  chk_q;
  logic [15:0] mem_data_q;
  logic        done_q;
  logic        err_q;
  logic        core_rst_n_q;

  logic        xfer;
  logic        start_ok;
  logic [15:0] len_full;
  logic        addr_wen;
  logic [15:0] addr_d;

  assign byte_ready_o = (state_q inside {StLenHi, StLenLo, StDatHi, StDatLo, StChk});
  assign mem_en_o     = (state_q == StWrite);
  assign mem_wr_o     = mem_en_o;
  assign xfer         = byte_valid_i & byte_ready_o;
  assign start_ok     = start_i & (state_q inside {StIdle, StDone, StErr});
  assign len_full     = {len_q[15:8], byte_in_i};

  // A new load rewinds the address; each write cycle steps it by one word (wraps silently).
  assign addr_wen = start_ok | (state_q == StWrite);
  assign addr_d   = start_ok ? BASE_ADDR : mem_addr_o + WordStep;

  imem_loader_dff #(
    .Width   (16),
    .ResetVal(BASE_ADDR)
  ) u_addr_ff (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .wen_i(addr_wen),
    .d_i  (addr_d),
    .q_o  (mem_addr_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      len_q        <= '0;
      count_q      <= '0;
      chk_q        <= '0;
      mem_data_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start_i) begin
            state_q      <= StLenHi;
            count_q      <= '0;
            chk_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
          end
        end
        StLenHi: begin
          if (xfer) begin
            len_q[15:8] <= byte_in_i;
            chk_q       <= chk_q ^ byte_in_i;
            state_q     <= StLenLo;
          end
        end
        StLenLo: begin
          if (xfer) begin
            len_q[7:0] <= byte_in_i;
            chk_q      <= chk_q ^ byte_in_i;
            if (len_full == 16'd0) begin
              state_q <= StChk;
            end else if (32'(len_full) > MAX_WORDS) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              state_q <= StDatHi;
            end
          end
        end
        StDatHi: begin
          if (xfer) begin
            mem_data_q[15:8] <= byte_in_i;
            chk_q            <= chk_q ^ byte_in_i;
            state_q          <= StDatLo;
          end
        end
        StDatLo: begin
          if (xfer) begin
            mem_data_q[7:0] <= byte_in_i;
            chk_q           <= chk_q ^ byte_in_i;
            state_q         <= StWrite;
          end
        end
        StWrite: begin
          count_q <= count_q + 16'd1;
          state_q <= (count_q + 16'd1 == len_q) ? StChk : StDatHi;
        end
        StChk: begin
          if (xfer) begin
            if (byte_in_i == chk_q) begin
              state_q      <= StDone;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_data_o   = mem_data_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign core_rst_n_o = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clean load, bad checksum, oversize length, empty load,
// stalled stream, mid-load reset and ignored start.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        done;
  logic        err;
  logic        core_rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          en_wr_diff = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .byte_valid_i(byte_valid),
    .byte_in_i   (byte_in),
    .byte_ready_o(byte_ready),
    .mem_en_o    (mem_en),
    .mem_wr_o    (mem_wr),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .done_o      (done),
    .err_o       (err),
    .core_rst_n_o(core_rst_n)
  );

  // Log every write cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
    end
    if (mem_en !== mem_wr) en_wr_diff++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_good_stream(input logic [7:0] chk, input int gap);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, gap);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, gap);
    send_byte(chk, 0);
  endtask

  task automatic check_two_words(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, 32'(wr_addr[0]), 32'h0000);
      check({tag, "_d0"}, 32'(wr_data[0]), 32'h1234);
      check({tag, "_a1"}, 32'(wr_addr[1]), 32'h0002);
      check({tag, "_d1"}, 32'(wr_data[1]), 32'hABCD);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_core", 32'(core_rst_n), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0000);
    check("rst_data", 32'(mem_data), 32'h0000);
    rst = 1'b0;
    @(negedge clk);

    // 00^02^12^34^AB^CD = 42
    pulse_start();
    check("start_ready", 32'(byte_ready), 32'd1);
    send_good_stream(8'h42, 0);
    check("ok_done", 32'(done), 32'd1);
    check("ok_err", 32'(err), 32'd0);
    check("ok_core", 32'(core_rst_n), 32'd1);
    check("ok_addr_end", 32'(mem_addr), 32'h0004);
    check_two_words("ok");
    repeat (3) @(negedge clk);
    check("ok_hold_done", 32'(done), 32'd1);

    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("restart_done_clr", 32'(done), 32'd0);
    send_good_stream(8'h43, 0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_core", 32'(core_rst_n), 32'd0);
    check_two_words("bad");

    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h80, 0);
    send_byte(8'h01, 0);
    check("big_err", 32'(err), 32'd1);
    check("big_ready", 32'(byte_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("big_nwr", 32'(wr_addr.size()), 32'd0);

    pulse_start();
    check("zero_err_clr", 32'(err), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_nwr", 32'(wr_addr.size()), 32'd0);

    pulse_start();
    send_good_stream(8'h42, 5);
    check("gap_done", 32'(done), 32'd1);
    check_two_words("gap");

    // Reset while sitting in DAT_LO of the second word.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    check("mid_ready_dat_lo", 32'(byte_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'h0000);
    check("mid_rst_data", 32'(mem_data), 32'h0000);
    check("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_in    = 8'hCD;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    check("mid_nwr", 32'(wr_addr.size()), 32'd1);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_good_stream(8'h42, 0);
    check("reload_done", 32'(done), 32'd1);
    check_two_words("reload");

    // start during DAT_HI must not restart the load.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h42, 0);
    check("ign_done", 32'(done), 32'd1);
    check_two_words("ign");

    check("en_eq_wr", 32'(en_wr_diff), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
